// File: rtl/link_cond_pkg.sv
// Shared constants, stage record and match helper for the conditional link-write pipe.
// Used by link_cond_pipe and link_stage_reg.
package link_cond_pkg;

  localparam int unsigned LINK_W          = 32;
  localparam logic [4:0]  LINK_REG_DEF    = 5'd31;
  localparam int unsigned LINK_OFFSET_DEF = 8;

  typedef struct packed {
    logic              valid;
    logic [LINK_W-1:0] value;
  } link_stage_t;

  // Register 0 is hard-wired, so a link aimed at it can never be a forwarding source.
  function automatic logic link_match(input link_stage_t stage,
                                      input logic [4:0]  addr,
                                      input logic [4:0]  link_reg);
    return stage.valid && (addr == link_reg) && (addr != 5'd0);
  endfunction

endpackage

// File: rtl/link_stage_reg.sv
// One pipeline stage of the link write: {valid, value} with a bubble input that
// clears the stage instead of loading it.
module link_stage_reg
  import link_cond_pkg::*;
#(
  parameter int unsigned WIDTH = LINK_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bubble,
  input  logic             d_valid,
  input  logic [WIDTH-1:0] d_value,
  output logic             q_valid,
  output logic [WIDTH-1:0] q_value
);

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // its predecessor's pre-edge value; blocking here would collapse E/M/W into one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_valid <= 1'b0;
      // NOTE: the value is reset too, so outputs are deterministic from reset
      // even though they are masked by valid downstream.
      q_value <= '0;
    end else if (bubble) begin
      q_valid <= 1'b0;
      q_value <= '0;
    end else begin
      q_valid <= d_valid;
      q_value <= d_value;
    end
  end

endmodule

// File: rtl/link_cond_pipe.sv
// Carries the conditional link write (BLTZAL, optionally BGEZAL) from D to W and
// forwards in-flight link values to D. Optional feature macro: LINK_COND_BGEZAL_EN.
module link_cond_pipe
  import link_cond_pkg::*;
#(
  parameter int unsigned WIDTH       = LINK_W,
  parameter logic [4:0]  LINK_REG    = LINK_REG_DEF,
  parameter int unsigned LINK_OFFSET = LINK_OFFSET_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             d_is_bltzal,
`ifdef LINK_COND_BGEZAL_EN
  input  logic             d_is_bgezal,
`endif
  input  logic             d_rs_neg,
  input  logic [WIDTH-1:0] d_pc,
  input  logic [4:0]       q_addr,
  output logic             fwd_hit,
  output logic [WIDTH-1:0] fwd_data,
  output logic             w_grf_we,
  output logic [4:0]       w_grf_addr,
  output logic [WIDTH-1:0] w_grf_wd
);

  logic             d_link;
  logic [WIDTH-1:0] d_link_value;

  logic             e_valid, m_valid, w_valid;
  logic [WIDTH-1:0] e_value, m_value, w_value;

  link_stage_t      e_stage, m_stage, w_stage;
  logic             e_hit, m_hit, w_hit;

`ifdef LINK_COND_BGEZAL_EN
  assign d_link = (d_is_bltzal & d_rs_neg) | (d_is_bgezal & ~d_rs_neg);

  // Decode never issues both link branches at once.
  a_one_link_request: assert property (
    @(posedge clk) disable iff (!reset) !(d_is_bltzal && d_is_bgezal)
  );
`else
  assign d_link = d_is_bltzal & d_rs_neg;
`endif

  assign d_link_value = d_pc + WIDTH'(LINK_OFFSET);

  // A stall bubbles E; the held D instruction re-presents next cycle, so the
  // link is counted once when the stall releases.
  link_stage_reg #(.WIDTH(WIDTH)) u_stage_e (
    .clk     (clk),
    .rst_n   (reset),
    .bubble  (stall),
    .d_valid (d_link),
    .d_value (d_link_value),
    .q_valid (e_valid),
    .q_value (e_value)
  );

  link_stage_reg #(.WIDTH(WIDTH)) u_stage_m (
    .clk     (clk),
    .rst_n   (reset),
    .bubble  (1'b0),
    .d_valid (e_valid),
    .d_value (e_value),
    .q_valid (m_valid),
    .q_value (m_value)
  );

  link_stage_reg #(.WIDTH(WIDTH)) u_stage_w (
    .clk     (clk),
    .rst_n   (reset),
    .bubble  (1'b0),
    .d_valid (m_valid),
    .d_value (m_value),
    .q_valid (w_valid),
    .q_value (w_value)
  );

  assign e_stage = '{valid: e_valid, value: LINK_W'(e_value)};
  assign m_stage = '{valid: m_valid, value: LINK_W'(m_value)};
  assign w_stage = '{valid: w_valid, value: LINK_W'(w_value)};

  assign e_hit = link_match(e_stage, q_addr, LINK_REG);
  assign m_hit = link_match(m_stage, q_addr, LINK_REG);
  assign w_hit = link_match(w_stage, q_addr, LINK_REG);

  // Youngest stage wins: E holds the most recent link.
  always_comb begin
    // NOTE: defaults first so no path leaves fwd_data unassigned (no latch).
    fwd_hit  = e_hit | m_hit | w_hit;
    fwd_data = '0;
    if (e_hit) begin
      fwd_data = e_value;
    end else if (m_hit) begin
      fwd_data = m_value;
    end else if (w_hit) begin
      fwd_data = w_value;
    end
  end

  assign w_grf_we   = w_valid;
  assign w_grf_addr = w_valid ? LINK_REG : 5'd0;
  assign w_grf_wd   = w_valid ? w_value : '0;

endmodule

// File: tb/tb_link_cond_pipe.sv
// Self-checking bench for link_cond_pipe: table-driven vectors with a write-back
// scoreboard, plus a hand-written mid-cycle reset sequence.
module tb_link_cond_pipe;
  import link_cond_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        d_is_bltzal;
  logic        d_is_bgezal;
  logic        d_rs_neg;
  logic [31:0] d_pc;
  logic [4:0]  q_addr;

  logic        fwd_hit, w_grf_we;
  logic [31:0] fwd_data, w_grf_wd;
  logic [4:0]  w_grf_addr;

  logic        fwd_hit0, w_grf_we0;
  logic [31:0] fwd_data0, w_grf_wd0;
  logic [4:0]  w_grf_addr0;

  always #5 clk = ~clk;

  link_cond_pipe dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .d_is_bltzal (d_is_bltzal),
`ifdef LINK_COND_BGEZAL_EN
    .d_is_bgezal (d_is_bgezal),
`endif
    .d_rs_neg    (d_rs_neg),
    .d_pc        (d_pc),
    .q_addr      (q_addr),
    .fwd_hit     (fwd_hit),
    .fwd_data    (fwd_data),
    .w_grf_we    (w_grf_we),
    .w_grf_addr  (w_grf_addr),
    .w_grf_wd    (w_grf_wd)
  );

  // Second copy targeting register 0: must never forward, still pulses its write.
  link_cond_pipe #(.LINK_REG(5'd0)) dut_r0 (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .d_is_bltzal (d_is_bltzal),
`ifdef LINK_COND_BGEZAL_EN
    .d_is_bgezal (d_is_bgezal),
`endif
    .d_rs_neg    (d_rs_neg),
    .d_pc        (d_pc),
    .q_addr      (q_addr),
    .fwd_hit     (fwd_hit0),
    .fwd_data    (fwd_data0),
    .w_grf_we    (w_grf_we0),
    .w_grf_addr  (w_grf_addr0),
    .w_grf_wd    (w_grf_wd0)
  );

  typedef struct {
    logic        stall;
    logic        bltzal;
    logic        bgezal;
    logic        neg;
    logic [31:0] pc;
    logic [4:0]  q;
    logic        exp_hit;
    logic [31:0] exp_fwd;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] wd;
  } wr_t;

  vec_t vecs[$];
  wr_t  sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic bl, input logic ng,
                              input logic [31:0] pc, input logic [4:0] q,
                              input logic hit, input logic [31:0] fwd,
                              input logic bg = 1'b0);
    vec_t v;
    v.stall = st; v.bltzal = bl; v.bgezal = bg; v.neg = ng;
    v.pc = pc; v.q = q; v.exp_hit = hit; v.exp_fwd = fwd;
    return v;
  endfunction

  function automatic wr_t expect_write(input vec_t v);
    wr_t  e;
    logic link;
    link = v.bltzal & v.neg;
`ifdef LINK_COND_BGEZAL_EN
    link = link | (v.bgezal & ~v.neg);
`endif
    e.we = link & ~v.stall;
    e.wd = e.we ? v.pc + 32'd8 : 32'd0;
    return e;
  endfunction

  task automatic sb_restart();
    wr_t z;
    z.we = 1'b0;
    z.wd = 32'd0;
    sb.delete();
    sb.push_back(z);
    sb.push_back(z);
  endtask

  // Drive one D-stage cycle, then compare W against the scoreboard and the
  // forwarding port against the vector's expectation.
  task automatic step(input vec_t v);
    wr_t e;
    @(negedge clk);
    stall       = v.stall;
    d_is_bltzal = v.bltzal;
    d_is_bgezal = v.bgezal;
    d_rs_neg    = v.neg;
    d_pc        = v.pc;
    q_addr      = v.q;
    sb.push_back(expect_write(v));
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("w_grf_we",   {31'd0, w_grf_we}, {31'd0, e.we});
    check("w_grf_addr", {27'd0, w_grf_addr}, e.we ? 32'd31 : 32'd0);
    check("w_grf_wd",   w_grf_wd, e.wd);
    check("fwd_hit",    {31'd0, fwd_hit}, {31'd0, v.exp_hit});
    check("fwd_data",   fwd_data, v.exp_fwd);
    check("r0_fwd_hit", {31'd0, fwd_hit0}, 32'd0);
    check("r0_w_we",    {31'd0, w_grf_we0}, {31'd0, e.we});
    check("r0_w_addr",  {27'd0, w_grf_addr0}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; stall = 1'b0; d_is_bltzal = 1'b0; d_is_bgezal = 1'b0;
    d_rs_neg = 1'b0; d_pc = 32'd0; q_addr = 5'd31;

    // stall, bltzal, neg, pc, q_addr, exp_hit, exp_fwd [, bgezal]
    vecs.push_back(mk(0, 1, 1, 32'h0000_3000, 31, 1, 32'h0000_3008));  // taken
    vecs.push_back(mk(0, 0, 0, 32'h0,         31, 1, 32'h0000_3008));
    vecs.push_back(mk(0, 0, 0, 32'h0,         31, 1, 32'h0000_3008));
    vecs.push_back(mk(0, 0, 0, 32'h0,         31, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0000_5000, 31, 0, 32'h0));           // not taken
    vecs.push_back(mk(0, 0, 1, 32'h0000_5004, 31, 0, 32'h0));
    vecs.push_back(mk(0, 1, 1, 32'h0000_3000, 31, 1, 32'h0000_3008));  // back-to-back
    vecs.push_back(mk(0, 1, 1, 32'h0000_3004, 31, 1, 32'h0000_300C));
    vecs.push_back(mk(0, 1, 1, 32'h0000_3008, 31, 1, 32'h0000_3010));
    vecs.push_back(mk(0, 0, 0, 32'h0,         30, 0, 32'h0));           // other reg
    vecs.push_back(mk(0, 0, 0, 32'h0,         31, 1, 32'h0000_3010));
    vecs.push_back(mk(0, 0, 0, 32'h0,          0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 1, 32'h0000_6000, 31, 0, 32'h0));           // stalled
    vecs.push_back(mk(1, 1, 1, 32'h0000_6000, 31, 0, 32'h0));
    vecs.push_back(mk(0, 1, 1, 32'h0000_6000, 31, 1, 32'h0000_6008));  // released
    vecs.push_back(mk(1, 1, 1, 32'h0000_7000, 31, 1, 32'h0000_6008));  // stall, link in E
    vecs.push_back(mk(0, 0, 0, 32'h0,         31, 1, 32'h0000_6008));
    vecs.push_back(mk(0, 0, 0, 32'h0,         31, 0, 32'h0));
    vecs.push_back(mk(0, 1, 1, 32'hFFFF_FFFC, 31, 1, 32'h0000_0004));  // wrap
    vecs.push_back(mk(0, 0, 0, 32'h0,         31, 1, 32'h0000_0004));
    vecs.push_back(mk(0, 0, 0, 32'h0,         31, 1, 32'h0000_0004));
    vecs.push_back(mk(0, 0, 0, 32'h0,         31, 0, 32'h0));
`ifdef LINK_COND_BGEZAL_EN
    vecs.push_back(mk(0, 0, 0, 32'h0000_4000, 31, 1, 32'h0000_4008, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,         31, 1, 32'h0000_4008));
    vecs.push_back(mk(0, 0, 0, 32'h0,         31, 1, 32'h0000_4008));
    vecs.push_back(mk(0, 0, 1, 32'h0000_4000, 31, 0, 32'h0, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,         31, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         31, 0, 32'h0));
`endif

    #12;
    check("reset_w_we",    {31'd0, w_grf_we}, 32'd0);
    check("reset_w_addr",  {27'd0, w_grf_addr}, 32'd0);
    check("reset_w_wd",    w_grf_wd, 32'd0);
    check("reset_fwd_hit", {31'd0, fwd_hit}, 32'd0);
    check("reset_fwd",     fwd_data, 32'd0);

    @(negedge clk);
    reset = 1'b1;
    sb_restart();

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i]);
    end

    // Fill E, M and W, then pull reset low mid-cycle.
    step(mk(0, 1, 1, 32'h0000_8000, 31, 1, 32'h0000_8008));
    step(mk(0, 1, 1, 32'h0000_8004, 31, 1, 32'h0000_800C));
    step(mk(0, 1, 1, 32'h0000_8008, 31, 1, 32'h0000_8010));
    @(negedge clk);
    d_is_bltzal = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("async_w_we",    {31'd0, w_grf_we}, 32'd0);
    check("async_w_addr",  {27'd0, w_grf_addr}, 32'd0);
    check("async_w_wd",    w_grf_wd, 32'd0);
    check("async_fwd_hit", {31'd0, fwd_hit}, 32'd0);
    check("async_fwd",     fwd_data, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    sb_restart();
    for (int i = 0; i < 4; i++) begin
      step(mk(0, 0, 0, 32'h0, 31, 0, 32'h0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
